// File: rtl/cpu_trace_checker.sv
// Streaming checker for CPU trace records (register and memory writes), one ASCII char per clock.
// Optional record/error counters are built only when CPU_CHECKER_CNT_EN is defined.
module cpu_trace_checker #(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned GRF_DIGITS  = 4,
  parameter int unsigned GRF_NUM     = 32,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_6fff,
  parameter logic [31:0] DM_HI       = 32'h0000_2fff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code,
  output logic [15:0] record_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [4:0] {
    S_IDLE, S_TIME0, S_TIME, S_PC0, S_PC, S_SP1, S_GRF0, S_GRF, S_GRF_SP,
    S_ADDR0, S_ADDR, S_ADDR_SP, S_LT, S_SP2, S_DATA, S_DONE_R, S_DONE_M
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_time;
  logic [31:0] r_pc;
  logic [13:0] r_grf;
  logic [31:0] r_addr;
  logic        r_is_mem;

  logic        w_is_dig;
  logic        w_is_alpha;
  logic        w_is_hex;
  logic [3:0]  w_dig;
  logic [3:0]  w_hex;
  logic [15:0] w_mask;

  always_comb begin
    w_is_dig   = (char >= "0") && (char <= "9");
    w_is_alpha = (char >= "a") && (char <= "f");
    w_is_hex   = w_is_dig || w_is_alpha;
    w_dig      = char[3:0];
    // 'a'..'f' are 0x61..0x66, so the low nibble plus 9 gives 10..15
    w_hex      = w_is_alpha ? (char[3:0] + 4'd9) : char[3:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_time   <= '0;
      r_pc     <= '0;
      r_grf    <= '0;
      r_addr   <= '0;
      r_is_mem <= 1'b0;
    end else begin
      // Any character not accepted below aborts the record; '^' restarts it
      r_state <= (char == "^") ? S_TIME0 : S_IDLE;
      case (r_state)
        S_TIME0: begin
          r_time <= '0;
          r_pc   <= '0;
          r_grf  <= '0;
          r_addr <= '0;
          r_cnt  <= '0;
          if (w_is_dig) begin
            r_state <= S_TIME;
            r_time  <= {28'b0, w_dig};
            r_cnt   <= 4'd1;
          end
        end
        S_TIME: begin
          if (w_is_dig && (r_cnt < 4'(TIME_DIGITS))) begin
            r_state <= S_TIME;
            r_time  <= r_time * 32'd10 + {28'b0, w_dig};
            r_cnt   <= r_cnt + 4'd1;
          end else if (char == "@") begin
            r_state <= S_PC0;
            r_cnt   <= '0;
          end
        end
        S_PC0, S_PC: begin
          if (w_is_hex && (r_cnt < 4'd8)) begin
            r_state <= S_PC;
            r_pc    <= {r_pc[27:0], w_hex};
            r_cnt   <= r_cnt + 4'd1;
          end else if ((r_state == S_PC) && (char == ":") && (r_cnt == 4'd8)) begin
            r_state <= S_SP1;
          end
        end
        S_SP1: begin
          if (char == " ") begin
            r_state <= S_SP1;
          end else if (char == "$") begin
            r_state  <= S_GRF0;
            r_is_mem <= 1'b0;
            r_cnt    <= '0;
          end else if (char == "*") begin
            r_state  <= S_ADDR0;
            r_is_mem <= 1'b1;
            r_cnt    <= '0;
          end
        end
        S_GRF0, S_GRF: begin
          if (w_is_dig && (r_cnt < 4'(GRF_DIGITS))) begin
            r_state <= S_GRF;
            r_grf   <= r_grf * 14'd10 + {10'b0, w_dig};
            r_cnt   <= r_cnt + 4'd1;
          end else if ((r_state == S_GRF) && (char == " ")) begin
            r_state <= S_GRF_SP;
          end else if ((r_state == S_GRF) && (char == "<")) begin
            r_state <= S_LT;
          end
        end
        S_GRF_SP: begin
          if (char == " ")      r_state <= S_GRF_SP;
          else if (char == "<") r_state <= S_LT;
        end
        S_ADDR0, S_ADDR: begin
          if (w_is_hex && (r_cnt < 4'd8)) begin
            r_state <= S_ADDR;
            r_addr  <= {r_addr[27:0], w_hex};
            r_cnt   <= r_cnt + 4'd1;
          end else if ((r_state == S_ADDR) && (r_cnt == 4'd8) && (char == " ")) begin
            r_state <= S_ADDR_SP;
          end else if ((r_state == S_ADDR) && (r_cnt == 4'd8) && (char == "<")) begin
            r_state <= S_LT;
          end
        end
        S_ADDR_SP: begin
          if (char == " ")      r_state <= S_ADDR_SP;
          else if (char == "<") r_state <= S_LT;
        end
        S_LT: begin
          if (char == "=") r_state <= S_SP2;
        end
        S_SP2: begin
          if (char == " ") begin
            r_state <= S_SP2;
          end else if (w_is_hex) begin
            r_state <= S_DATA;
            r_cnt   <= 4'd1;
          end
        end
        S_DATA: begin
          if (w_is_hex && (r_cnt < 4'd8)) begin
            r_state <= S_DATA;
            r_cnt   <= r_cnt + 4'd1;
          end else if ((char == "#") && (r_cnt == 4'd8)) begin
            r_state <= r_is_mem ? S_DONE_M : S_DONE_R;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    format_type = 2'b00;
    error_code  = '0;
    w_mask      = (freq >> 1) - 16'd1;
    if ((r_state == S_DONE_R) || (r_state == S_DONE_M)) begin
      format_type   = (r_state == S_DONE_R) ? 2'b01 : 2'b10;
      error_code[0] = (r_time & {16'b0, w_mask}) != '0;
      error_code[1] = (r_pc < PC_LO) || (r_pc > PC_HI) || (r_pc[1:0] != 2'b00);
      if (r_state == S_DONE_M)
        error_code[2] = (r_addr > DM_HI) || (r_addr[1:0] != 2'b00);
      else
        error_code[3] = {18'b0, r_grf} >= 32'(GRF_NUM);
    end
  end

`ifdef CPU_CHECKER_CNT_EN
  logic [15:0] r_record_cnt;
  logic [15:0] r_err_cnt;
  logic        w_done;

  assign w_done = (format_type != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_record_cnt <= '0;
      r_err_cnt    <= '0;
    end else if (w_done) begin
      if (r_record_cnt != '1)
        r_record_cnt <= r_record_cnt + 16'd1;
      if ((error_code != '0) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign record_cnt = r_record_cnt;
  assign err_cnt    = r_err_cnt;
`else
  assign record_cnt = '0;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Scoreboard bench for cpu_trace_checker: records are built from random fields, expected flags
// are derived arithmetically from those fields, and a negedge monitor checks every pulse.
module tb_cpu_trace_checker;

  logic        clk;
  logic        reset;
  logic [7:0]  char;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  logic [15:0] record_cnt;
  logic [15:0] err_cnt;

  cpu_trace_checker dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code),
    .record_cnt  (record_cnt),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ft;
    logic [3:0] ec;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned m_rec   = 0;
  int unsigned m_err   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: every pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (format_type != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("spurious_pulse", 32'(format_type), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("format_type", 32'(format_type), 32'(e.ft));
          check("error_code", 32'(error_code), 32'(e.ec));
        end
      end else if (error_code != 4'd0) begin
        check("error_code_idle", 32'(error_code), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [1:0] ft, input logic [3:0] ec);
    exp_t e;
    e.ft = ft;
    e.ec = ec;
    exp_q.push_back(e);
    m_rec++;
    if (ec != 4'd0) m_err++;
  endtask

  task automatic send(input logic [7:0] c);
    char = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(8'h2e);
  endtask

  task automatic check_cnt(input string tag);
`ifdef CPU_CHECKER_CNT_EN
    check({tag, "_record_cnt"}, 32'(record_cnt), m_rec);
    check({tag, "_err_cnt"}, 32'(err_cnt), m_err);
`else
    check({tag, "_record_cnt"}, 32'(record_cnt), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  function automatic string dec_str(input int unsigned v, input int unsigned n);
    string s = "";
    for (int unsigned i = 0; i < n; i++) begin
      s = {$sformatf("%0d", v % 10), s};
      v = v / 10;
    end
    return s;
  endfunction

  function automatic string spaces(input int unsigned n);
    string s = "";
    for (int unsigned i = 0; i < n; i++) s = {s, " "};
    return s;
  endfunction

  function automatic int unsigned p10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // bad: 0 valid, 1 long time, 2 short pc, 3 missing '<', 4 long data, 5 long grf, 6 uppercase data
  task automatic gen_record(input int unsigned bad, output string s, output logic [1:0] ft,
                            output logic [3:0] ec);
    int unsigned tdig, tval, gdig, gval, half;
    logic        is_mem;
    logic [31:0] pc, addr;
    string       ts, ps, fs, ls, ds;
    is_mem = 1'($urandom_range(0, 1));
    if (bad == 5) is_mem = 1'b0;
    tdig = $urandom_range(1, 4);
    tval = $urandom_range(0, p10(tdig) - 1);
    if (bad == 1) begin
      tdig = 5;
      tval = $urandom_range(10000, 99999);
    end
    ts = dec_str(tval, tdig);
    if ($urandom_range(0, 1) == 1) pc = 32'h3000 + ($urandom_range(0, 32'h0fff) << 2);
    else                           pc = $urandom_range(32'h2ff0, 32'h7010);
    ps = $sformatf("%08h", pc);
    if (bad == 2) ps = ps.substr(1, 7);
    addr = '0;
    gval = 0;
    if (is_mem) begin
      case ($urandom_range(0, 2))
        0:       addr = $urandom_range(0, 32'h0bff) << 2;
        1:       addr = $urandom_range(32'h2ff0, 32'h3010);
        default: addr = $urandom;
      endcase
      fs = {"*", $sformatf("%08h", addr), spaces($urandom_range(0, 2))};
    end else begin
      gval = $urandom_range(0, 40);
      gdig = (gval >= 10) ? $urandom_range(2, 4) : $urandom_range(1, 4);
      if (bad == 5) gdig = 5;
      fs = {"$", dec_str(gval, gdig), spaces($urandom_range(0, 2))};
    end
    ls = (bad == 3) ? "=" : "<=";
    ds = $sformatf("%08h", $urandom);
    if (bad == 4) ds = {ds, "0"};
    if (bad == 6) ds = {"A", ds.substr(1, 7)};
    s = {"^", ts, "@", ps, ":", spaces($urandom_range(0, 2)), fs, ls,
         spaces($urandom_range(0, 2)), ds, "#"};
    half  = 32'(freq) >> 1;
    ft    = is_mem ? 2'b10 : 2'b01;
    ec    = '0;
    ec[0] = (tval % half) != 0;
    ec[1] = (pc < 32'h3000) || (pc > 32'h6fff) || (pc % 4 != 0);
    ec[2] = is_mem && ((addr > 32'h2fff) || (addr % 4 != 0));
    ec[3] = !is_mem && (gval >= 32);
  endtask

  initial begin
    string       s;
    logic [1:0]  ft;
    logic [3:0]  ec;
    int unsigned bad;

    reset = 1'b1;
    char  = 8'h00;
    freq  = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_format_type", 32'(format_type), 32'd0);
    check("rst_error_code", 32'(error_code), 32'd0);
    check("rst_record_cnt", 32'(record_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b0;
    idle(2);

    push_exp(2'b01, 4'b0000);
    send_str("^10@00003000: $1 <= 0000000a#");
    idle(2);
    check_cnt("reg_ok");

    push_exp(2'b10, 4'b0011);
    send_str("^11@00003002: *00000004 <= 00000001#");
    idle(2);
    check_cnt("mem_time_pc");

    push_exp(2'b10, 4'b0100);
    send_str("^8@00003004: *00003000 <= 00000000#");
    push_exp(2'b01, 4'b1000);
    send_str("^8@00003004: $40 <= 00000000#");
    idle(2);
    check_cnt("addr_grf");

    send_str("^12345@00003000: $1 <= 00000000#");
    idle(2);
    check_cnt("long_time");
    send_str("^8@3000: $1 <= 00000000#");
    idle(2);
    check_cnt("short_pc");
    send_str("^8@00003000: $1 = 00000000#");
    idle(2);
    check_cnt("missing_lt");

    push_exp(2'b01, 4'b0000);
    send_str("^8@0000^4@00003000: $2 <= 00000001#");
    idle(2);
    check_cnt("restart");

    send_str("^8@00003000: $1 <= 0000");
    reset = 1'b1;
    m_rec = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_str("0000#");
    idle(2);
    check_cnt("mid_reset");
    push_exp(2'b01, 4'b0000);
    send_str("^12@00003000: $3 <= 00000000#");
    idle(2);
    check_cnt("after_reset");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        idle(1);
        freq = 16'((2 << $urandom_range(0, 4)) | $urandom_range(0, 1));
      end
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      gen_record(bad, s, ft, ec);
      if (bad == 0) push_exp(ft, ec);
      send_str(s);
      if (n % 10 == 9) begin
        idle(2);
        check_cnt("random");
      end
    end

    idle(5);
    check("pending_expectations", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
